persp_div: RTL and testbench
============================

# persp_div

Perspective-correction divider stage. Consumes the screen-space-interpolated attribute A' = a/w and the interpolated 1/w, and produces the perspective-correct attribute a = A' / (1/w) in the same signed Q format. Sits directly downstream of the incremental attribute interpolator. Its output feeds the fragment attribute bus. It uses an iterative restoring divider with a valid/ready handshake on both sides, one operation in flight at a time.

## Interface
- WIDTH, 32, total bits of every Q operand and of the result
- FRAC, 16, fractional bits; format Q(WIDTH-FRAC-1).FRAC
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- in_valid  in  1  operands present
- in_ready  out  1  stage can accept; high only in IDLE
- num  in  WIDTH  signed A' (interpolated a/w)
- den  in  WIDTH  signed 1/w
- out_valid  out  1  result present; high only in DONE
- out_ready  in  1  consumer accepts result
- quot  out  WIDTH  signed perspective-correct attribute
- sat  out  1  result was clamped (overflow or divide-by-zero)
- divz  out  1  den <= 0 was presented

## Operation
- States are IDLE, DIV, FIX and DONE. Reset enters IDLE with quot=0, sat=0, divz=0, out_valid=0, in_ready=1, and the iteration counter at 0.
- IDLE: on in_valid&in_ready, latch sign = num[WIDTH-1].
  - Latch mag = |num| as a WIDTH-bit unsigned value, so the most negative num gives 2^(WIDTH-1) exactly.
  - Latch the divisor and clear the remainder.
  - If den <= 0, set divz and go to FIX. Otherwise go to DIV.
- DIV: the dividend is mag << FRAC, which is WIDTH+FRAC bits. Each cycle performs one restoring step, MSB first, and shifts one quotient bit into a WIDTH+FRAC-bit register.
  - The step count is N = WIDTH+FRAC.
  - After step N, go to FIX.
- FIX: compute the magnitude result q.
  - Rounding is applied to q when enabled (see Configuration).
  - If q > 2^(WIDTH-1)-1, clamp q to 2^(WIDTH-1)-1 and set sat.
  - If divz: q = 2^(WIDTH-1)-1 and sat=1.
  - quot = sign ? -q : q. Saturation is symmetric, so quot is never 0x80..0. The result 0 is never negative zero.
  - Go to DONE.
- DONE: hold quot, sat and divz stable. On out_ready, go to IDLE. sat and divz stay valid only while out_valid is high.
- There is no input/output overlap: a new operand is never accepted in the same cycle a result is consumed.
- Asynchronous reset in any state aborts the operation immediately and discards it. No result is emitted.

## Timing
- The accept edge is T, where in_valid&in_ready is sampled high. in_ready falls after T.
- Normal path: DIV occupies edges T+1..T+N and FIX occurs at edge T+N+1. out_valid is high from T+N+1, a latency of N+1 edges (49 at default parameters).
- Divide-by-zero path: FIX at T+1 and out_valid from T+1, a latency of 1 edge.
- When out_valid&out_ready is sampled at edge R, out_valid is low and in_ready is high after R. The earliest next accept is edge R+1.
- Throughput is one result per N+3 cycles at best.
- in_ready and out_valid are decoded from the state register only. Neither depends combinationally on in_valid or out_ready.

## Configuration
- Macro: PERSP_DIV_ROUND_EN.
- Defined: round to nearest, half away from zero. If 2*remainder >= divisor after step N, q += 1 before the saturation check. Rounding is applied to the magnitude, so it is symmetric in sign.
- Undefined: truncate toward zero, so q is the raw quotient. The rounding comparator and its adder are not built.
- Latency is identical in both builds.

## Test plan
All scenarios use the defaults, WIDTH=32 and FRAC=16.
- Basic: num=0x00030000, den=0x00020000 -> quot=0x00018000, sat=0, divz=0. out_valid 49 edges after accept.
- Rounding: num=0x00000002, den=0x00030000 -> quot=0x00000001 with PERSP_DIV_ROUND_EN, 0x00000000 without. With num=-2 the results are 0xFFFFFFFF and 0x00000000.
- Overflow: num=0x7FFF0000, den=0x00008000 -> quot=0x7FFFFFFF, sat=1. With num=0x80000000 -> quot=0x80000001, sat=1.
- Divide-by-zero: den=0, num=0xFFFFFFFB -> quot=0x80000001, sat=1, divz=1, out_valid 1 edge after accept. den=0xFFFF0000 behaves the same.
- Backpressure: hold out_ready low for 10 cycles after out_valid. quot, sat and divz must stay stable, in_ready must stay low, and a pending in_valid must not be accepted. Release out_ready, and in_ready rises the following cycle.
- Reset mid-DIV: assert rst_n low at step 20. All outputs are 0 and in_ready=1 immediately. A new operation after reset completes with the correct value and the full 49-edge latency.

Source files
------------

// File: rtl/persp_div.sv
// Perspective-correction divider: quot = num / den in signed Q(WIDTH-FRAC-1).FRAC,
// iterative restoring divider. Define PERSP_DIV_ROUND_EN for round-half-away-from-zero.
module persp_div #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic             sat,
  output logic             divz
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
  localparam logic [N:0]    Q_MAX     = {{(N-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t            state;
  logic              sign;
  logic [N-1:0]      dq;     // dividend shifts out the MSB while quotient bits shift in
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  dsr;
  logic [CW-1:0]     cnt;

  logic [WIDTH-1:0]  mag_in;
  logic              den_nonpos;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH:0]    diff;
  logic [N:0]        q_rnd;
  logic              over;
  logic [WIDTH-1:0]  q_mag;
  logic [WIDTH-1:0]  quot_fix;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Two's-complement negate treated as unsigned: the most negative num maps to 2^(WIDTH-1).
  assign mag_in     = num[WIDTH-1] ? (~num + WIDTH'(1)) : num;
  assign den_nonpos = den[WIDTH-1] | (den == '0);

  assign rem_sh = {rem, dq[N-1]};
  assign diff   = rem_sh - {1'b0, dsr};

`ifdef PERSP_DIV_ROUND_EN
  logic round_up;
  assign round_up = ({rem, 1'b0} >= {1'b0, dsr});
  assign q_rnd    = {1'b0, dq} + {{N{1'b0}}, round_up};
`else
  assign q_rnd    = {1'b0, dq};
`endif

  assign over     = (q_rnd > Q_MAX);
  assign q_mag    = (divz || over) ? Q_MAX[WIDTH-1:0] : q_rnd[WIDTH-1:0];
  assign quot_fix = sign ? (~q_mag + WIDTH'(1)) : q_mag;

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sign  <= 1'b0;
      dq    <= '0;
      rem   <= '0;
      dsr   <= '0;
      cnt   <= '0;
      quot  <= '0;
      sat   <= 1'b0;
      divz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign  <= num[WIDTH-1];
            dq    <= {mag_in, {FRAC{1'b0}}};
            rem   <= '0;
            dsr   <= den;
            cnt   <= '0;
            sat   <= 1'b0;
            divz  <= den_nonpos;
            state <= den_nonpos ? FIX : DIV;
          end
        end
        DIV: begin
          // diff[WIDTH] is the borrow: set means the trial subtraction is restored.
          dq  <= {dq[N-2:0], ~diff[WIDTH]};
          rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == LAST_STEP) state <= FIX;
        end
        FIX: begin
          quot  <= quot_fix;
          sat   <= divz | over;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_persp_div.sv
// Directed self-checking bench for persp_div at WIDTH=32, FRAC=16.
// Expected rounding results follow PERSP_DIV_ROUND_EN when it is defined.
module tb_persp_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num;
  logic [31:0] den;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quot;
  logic        sat;
  logic        divz;

  int n_checks = 0;
  int n_fail   = 0;

  persp_div #(.WIDTH(32), .FRAC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .den       (den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .sat       (sat),
    .divz      (divz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands and return 1 ns after the accept edge.
  task automatic start_op(input logic [31:0] n, input logic [31:0] d);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    num      = n;
    den      = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] eq, input logic es, input logic ez, input int el);
    int lat;
    start_op(n, d);
    wait_done(lat);
    check({tag, ".lat"},  64'(lat), 64'(el));
    check({tag, ".quot"}, {32'd0, quot}, {32'd0, eq});
    check({tag, ".sat"},  {63'd0, sat},  {63'd0, es});
    check({tag, ".divz"}, {63'd0, divz}, {63'd0, ez});
    check({tag, ".busy"}, {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, ".ov_low"}, {63'd0, out_valid}, 64'd0);
    check({tag, ".rdy_hi"}, {63'd0, in_ready},  64'd1);
  endtask

  initial begin
    logic [31:0] rnd_pos;
    logic [31:0] rnd_neg;
    logic [31:0] two_thirds;
    int lat;

`ifdef PERSP_DIV_ROUND_EN
    rnd_pos    = 32'h0000_0001;
    rnd_neg    = 32'hFFFF_FFFF;
    two_thirds = 32'h0000_AAAB;
`else
    rnd_pos    = 32'h0000_0000;
    rnd_neg    = 32'h0000_0000;
    two_thirds = 32'h0000_AAAA;
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    num       = '0;
    den       = '0;
    #12;
    check("rst.quot",      {32'd0, quot},      64'd0);
    check("rst.sat",       {63'd0, sat},       64'd0);
    check("rst.divz",      {63'd0, divz},      64'd0);
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst.in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic",      32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 49);
    run_op("neg_basic",  32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b0, 1'b0, 49);
    run_op("third",      32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 49);
    run_op("two_thirds", 32'h0002_0000, 32'h0003_0000, two_thirds,    1'b0, 1'b0, 49);
    run_op("rnd_pos",    32'h0000_0002, 32'h0003_0000, rnd_pos,       1'b0, 1'b0, 49);
    run_op("rnd_neg",    32'hFFFF_FFFE, 32'h0003_0000, rnd_neg,       1'b0, 1'b0, 49);
    run_op("ovf_pos",    32'h7FFF_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b1, 1'b0, 49);
    run_op("ovf_neg",    32'h8000_0000, 32'h0000_8000, 32'h8000_0001, 1'b1, 1'b0, 49);
    run_op("divz_zero",  32'hFFFF_FFFB, 32'h0000_0000, 32'h8000_0001, 1'b1, 1'b1, 1);
    run_op("divz_neg",   32'hFFFF_FFFB, 32'hFFFF_0000, 32'h8000_0001, 1'b1, 1'b1, 1);
    run_op("divz_pos",   32'h0000_0005, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1);

    // Backpressure: result must hold and a pending operand must wait.
    start_op(32'h0003_0000, 32'h0002_0000);
    wait_done(lat);
    check("bp.lat", 64'(lat), 64'd49);
    num      = 32'h0001_0000;
    den      = 32'h0001_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp.quot",      {32'd0, quot},      64'h0001_8000);
      check("bp.sat",       {63'd0, sat},       64'd0);
      check("bp.divz",      {63'd0, divz},      64'd0);
      check("bp.in_ready",  {63'd0, in_ready},  64'd0);
      check("bp.out_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp.rel_rdy", {63'd0, in_ready},  64'd1);
    check("bp.rel_ov",  {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("bp.not_taken", {63'd0, in_ready}, 64'd1);

    // Asynchronous reset in the middle of the divide loop.
    start_op(32'h0005_0000, 32'h0002_0000);
    repeat (19) @(posedge clk);
    #1;
    check("mid.busy",  {63'd0, in_ready},  64'd0);
    check("mid.no_ov", {63'd0, out_valid}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.quot",      {32'd0, quot},      64'd0);
    check("arst.sat",       {63'd0, sat},       64'd0);
    check("arst.divz",      {63'd0, divz},      64'd0);
    check("arst.out_valid", {63'd0, out_valid}, 64'd0);
    check("arst.in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 49);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
